teller_scheduler: RTL and testbench
===================================

# teller_scheduler

Dispatcher that sits between the customer queue and up to three teller windows. It tracks each teller's duty and serving status and calls the head-of-queue customer to a free teller, choosing round-robin among free tellers. It drives the queue's "leaving" photocell input when a called customer is served or fails to show. It also publishes the on-duty teller count that the queue uses for wait-time estimation.

## Interface
Parameters:
- n, 3, queue count width minus one; Pcount is n+1 bits.
- CALL_TIMEOUT, 15, cycles a call stays displayed before it is declared a no-show.
- GUARD, 4, hold-off cycles after leaveN while the queue's synchronized count settles.

Ports:
- reset  in  1  asynchronous, active-low.
- clock  in  1  clock.
- Pcount  in  n+1  current queue occupancy.
- emptyFlag  in  1  queue empty.
- tellerOn  in  3  level; bit i means teller i+1 is on duty.
- tellerDone  in  3  one-cycle pulse; teller i+1 has finished its customer.
- custAck  in  3  one-cycle pulse; the customer has arrived at window i+1.
- Tcount  out  2  registered popcount of tellerOn; drives the queue's Tcount input.
- callValid  out  1  call display active.
- callTeller  out  2  called teller number 1..3; 0 when callValid=0.
- leaveN  out  1  active-low one-cycle pulse; wired to the queue's phcTwo input.
- busy  out  3  bit i high while teller i+1 is in SERVING.
- noShowCount  out  8  saturating count of timed-out calls.

## Operation
Per-teller FSM. States are OFF, FREE, CALLING and SERVING.
- In any state, tellerOn[i]=0 sends the teller to OFF at the next edge. This has priority over every other event. Any customer being served is dropped, and there is no queue effect.
- OFF to FREE: on tellerOn[i]=1.
- FREE to CALLING: when the dispatcher grants teller i.
- CALLING to SERVING: on custAck[i].
- CALLING to FREE: on timeout.
- SERVING to FREE: on tellerDone[i].
- tellerDone[i] outside SERVING is ignored. custAck[i] outside CALLING is ignored.

Dispatcher FSM. States are D_IDLE, D_CALL and D_GUARD.
- D_IDLE: when emptyFlag=0, Pcount≠0 and any teller is FREE, grant one teller. The grant goes to the first FREE teller in the order lastGrant+1, +2, +3 (mod 3). Then:
  - lastGrant is set to the granted teller.
  - The call timer is cleared.
  - The dispatcher moves to D_CALL.
- D_CALL: callValid=1, and callTeller is the granted index plus 1. Exit conditions, in priority order:
  - Granted teller goes OFF: abort to D_IDLE. No leaveN pulse, no count.
  - custAck on the granted teller: pulse leaveN and go to D_GUARD.
  - Timer reaches CALL_TIMEOUT-1: treat as a no-show. Pulse leaveN, increment noShowCount (holding at 255), return the teller to FREE and go to D_GUARD. The head customer is still removed from the queue.
- custAck on a non-granted teller is ignored.
- D_GUARD: count GUARD cycles, then go to D_IDLE. This prevents a call on a stale Pcount or emptyFlag.
- Only one teller is ever in CALLING.

Width and arithmetic rules:
- The call timer is $clog2(CALL_TIMEOUT) bits.
- The guard counter is $clog2(GUARD+1) bits.
- Tcount = tellerOn[0]+tellerOn[1]+tellerOn[2], maximum 3, with no overflow.

## Timing
Reset values:
- Teller FSMs: all OFF.
- Dispatcher: D_IDLE, lastGrant=2, so teller 1 has first priority.
- Outputs: callValid=0, callTeller=0, leaveN=1, busy=0, Tcount=0, noShowCount=0.
- Reset is asynchronous and may arrive mid-call. Outputs return to these values immediately, and no leaveN pulse is emitted.

Cycle-level behaviour:
- Tcount follows tellerOn with 1 cycle of latency.
- A grant condition sampled at edge k gives callValid=1 from edge k+1.
- custAck sampled at edge k gives the following from edge k+1:
  - leaveN low for exactly one cycle;
  - busy[i]=1;
  - callValid=0 and callTeller=0.
- A timeout gives leaveN low in the cycle after the timer reaches CALL_TIMEOUT-1. callValid is high for exactly CALL_TIMEOUT cycles.
- The earliest next callValid is GUARD+1 cycles after the leaveN pulse.
- Simultaneous custAck and timeout: ack wins, and noShowCount does not increment.
- Simultaneous tellerOn drop and custAck on the granted teller: abort wins.

## Structure
Package bank_pkg holds:
- Teller state encoding (OFF, FREE, CALLING, SERVING) and dispatcher state encoding (D_IDLE, D_CALL, D_GUARD).
- MAX_TELLERS=3.
- The idle, coming and leaving queue encodings, shared with the queue.

Sub-module teller_fsm is instantiated three times. Its inputs are on, grant, ack, timeout and done. Its outputs are its state, plus free and busy. Dispatcher, round-robin pointer, timers and Tcount live in teller_scheduler.

## Test plan
- Reset, then tellerOn=3'b001, Pcount=2, emptyFlag=0 -> Tcount=1; callTeller=1; custAck[0] -> one low cycle of leaveN and busy=3'b001.
- All three tellers FREE, queue=5, ack each call -> callTeller sequence 1,2,3,1; successive calls are at least GUARD+1 cycles apart.
- Call with no custAck -> callValid high for 15 cycles, one leaveN pulse, noShowCount=1, teller back to FREE.
- tellerOn[1] dropped while teller 2 is CALLING -> callValid falls, leaveN stays 1, state OFF, Tcount decrements a cycle later.
- custAck in the same cycle the timer hits 14 -> served, noShowCount unchanged. custAck on a non-called teller -> ignored.
- Reset asserted mid-D_CALL -> all outputs at reset values asynchronously; no leaveN pulse.

Source files
------------

// File: rtl/bank_pkg.sv
// Shared teller/dispatcher state encodings and queue event codes for the bank slice.
// Pure declarations: no latency, no backpressure.
package bank_pkg;

   localparam int MAX_TELLERS = 3;

   typedef enum logic [1:0] {
      OFF     = 2'd0,
      FREE    = 2'd1,
      CALLING = 2'd2,
      SERVING = 2'd3
   } teller_state_t;

   typedef enum logic [1:0] {
      D_IDLE  = 2'd0,
      D_CALL  = 2'd1,
      D_GUARD = 2'd2
   } disp_state_t;

   typedef enum logic [1:0] {
      Q_IDLE    = 2'd0,
      Q_COMING  = 2'd1,
      Q_LEAVING = 2'd2
   } queue_ev_t;

   // Teller index 'step' positions after 'base', wrapping over the three windows.
   function automatic logic [1:0] rr_next(input logic [1:0] base, input int step);
      int s;
      s = (int'(base) + step) % MAX_TELLERS;
      return s[1:0];
   endfunction

endpackage

// File: rtl/teller_scheduler_if.sv
// Queue/teller-window bundle seen by the scheduler: master drives the stimulus side,
// slave is the scheduler; no latency, pulses and levels only (no backpressure).
interface teller_scheduler_if #(
   parameter int n = 3
);
   logic [n:0] Pcount;
   logic       emptyFlag;
   logic [2:0] tellerOn;
   logic [2:0] tellerDone;
   logic [2:0] custAck;
   logic [1:0] Tcount;
   logic       callValid;
   logic [1:0] callTeller;
   logic       leaveN;
   logic [2:0] busy;
   logic [7:0] noShowCount;

   modport master (
      output Pcount, emptyFlag, tellerOn, tellerDone, custAck,
      input  Tcount, callValid, callTeller, leaveN, busy, noShowCount
   );

   modport slave (
      input  Pcount, emptyFlag, tellerOn, tellerDone, custAck,
      output Tcount, callValid, callTeller, leaveN, busy, noShowCount
   );
endinterface

// File: rtl/teller_scheduler_teller_fsm.sv
// One teller window's duty/serving state; every event lands at the next edge (1 cycle).
// No backpressure: off-duty overrides all events, stray done/ack pulses are dropped.
module teller_fsm
   import bank_pkg::*;
(
   input  logic          clock,
   input  logic          reset,
   input  logic          on,
   input  logic          grant,
   input  logic          ack,
   input  logic          timeout,
   input  logic          done,
   output teller_state_t state,
   output logic          free,
   output logic          busy
);

   teller_state_t state_d;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= OFF;
      else        state <= state_d;
   end

   always_comb begin
      state_d = state;
      if (!on) begin
         state_d = OFF;
      end else begin
         case (state)
            OFF:     state_d = FREE;
            FREE:    if (grant) state_d = CALLING;
            CALLING: begin
               // An ack in the timeout cycle still counts as served.
               if (ack)          state_d = SERVING;
               else if (timeout) state_d = FREE;
            end
            SERVING: if (done) state_d = FREE;
            default: state_d = OFF;
         endcase
      end
   end

   assign free = (state == FREE);
   assign busy = (state == SERVING);

endmodule

// File: rtl/teller_scheduler.sv
// Calls the head customer to a free teller round-robin and pulses leaveN on serve/no-show.
// Call visible 1 cycle after grant condition; no backpressure, GUARD hold-off after each leave.
module teller_scheduler
   import bank_pkg::*;
#(
   parameter int n            = 3,
   parameter int CALL_TIMEOUT = 15,
   parameter int GUARD        = 4
) (
   input  logic              reset,
   input  logic              clock,
   teller_scheduler_if.slave bus
);

   localparam int TW = $clog2(CALL_TIMEOUT);
   localparam int GW = $clog2(GUARD + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(CALL_TIMEOUT - 1);
   localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

   teller_state_t t_state [MAX_TELLERS];
   logic [2:0]    t_free, t_busy, t_grant, t_timeout;
   logic [2:0]    eligible, calling_vec;

   disp_state_t   d_state, d_next;
   logic [1:0]    last_grant, last_grant_d;
   logic [1:0]    grant_idx, grant_idx_d;
   logic [TW-1:0] timer, timer_d;
   logic [GW-1:0] guard_cnt, guard_cnt_d;
   logic [7:0]    noshow, noshow_d;
   logic          leave_d, leave_n;
   logic [1:0]    tcount;
   logic [1:0]    pick, cand;
   logic          pick_vld;
   logic          queue_ready;

   for (genvar i = 0; i < MAX_TELLERS; i++) begin : g_teller
      teller_fsm u_teller (
         .clock   (clock),
         .reset   (reset),
         .on      (bus.tellerOn[i]),
         .grant   (t_grant[i]),
         .ack     (bus.custAck[i]),
         .timeout (t_timeout[i]),
         .done    (bus.tellerDone[i]),
         .state   (t_state[i]),
         .free    (t_free[i]),
         .busy    (t_busy[i])
      );
      assign calling_vec[i] = (t_state[i] == CALLING);
   end

   // A teller dropping duty this cycle must not be granted.
   assign eligible    = t_free & bus.tellerOn;
   assign queue_ready = !bus.emptyFlag && (bus.Pcount != {(n+1){1'b0}});

   always_comb begin
      pick_vld = 1'b0;
      pick     = 2'd0;
      cand     = 2'd0;
      for (int k = 1; k <= MAX_TELLERS; k++) begin
         cand = rr_next(last_grant, k);
         if (!pick_vld && eligible[cand]) begin
            pick_vld = 1'b1;
            pick     = cand;
         end
      end
   end

   always_comb begin
      d_next       = d_state;
      last_grant_d = last_grant;
      grant_idx_d  = grant_idx;
      timer_d      = timer;
      guard_cnt_d  = guard_cnt;
      noshow_d     = noshow;
      leave_d      = 1'b0;
      t_grant      = 3'b000;
      t_timeout    = 3'b000;
      case (d_state)
         D_IDLE: begin
            if (queue_ready && pick_vld) begin
               t_grant      = 3'b001 << pick;
               grant_idx_d  = pick;
               last_grant_d = pick;
               timer_d      = '0;
               d_next       = D_CALL;
            end
         end
         D_CALL: begin
            if (!bus.tellerOn[grant_idx]) begin
               d_next = D_IDLE;
            end else if (bus.custAck[grant_idx]) begin
               leave_d     = 1'b1;
               guard_cnt_d = '0;
               d_next      = D_GUARD;
            end else if (timer == TIMER_LAST) begin
               // No-show: the head customer is still taken off the queue.
               leave_d     = 1'b1;
               t_timeout   = 3'b001 << grant_idx;
               guard_cnt_d = '0;
               d_next      = D_GUARD;
               if (noshow != 8'hFF) noshow_d = noshow + 8'd1;
            end else begin
               timer_d = timer + TW'(1);
            end
         end
         D_GUARD: begin
            if (guard_cnt == GUARD_LAST) d_next = D_IDLE;
            else                         guard_cnt_d = guard_cnt + GW'(1);
         end
         default: d_next = D_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         d_state    <= D_IDLE;
         last_grant <= 2'd2;
         grant_idx  <= 2'd0;
         timer      <= '0;
         guard_cnt  <= '0;
         noshow     <= 8'd0;
         leave_n    <= 1'b1;
         tcount     <= 2'd0;
      end else begin
         d_state    <= d_next;
         last_grant <= last_grant_d;
         grant_idx  <= grant_idx_d;
         timer      <= timer_d;
         guard_cnt  <= guard_cnt_d;
         noshow     <= noshow_d;
         leave_n    <= !leave_d;
         tcount     <= {1'b0, bus.tellerOn[0]} + {1'b0, bus.tellerOn[1]} + {1'b0, bus.tellerOn[2]};
      end
   end

   assign bus.Tcount      = tcount;
   assign bus.callValid   = (d_state == D_CALL);
   assign bus.callTeller  = (d_state == D_CALL) ? grant_idx + 2'd1 : 2'd0;
   assign bus.leaveN      = leave_n;
   assign bus.busy        = t_busy;
   assign bus.noShowCount = noshow;

   a_single_calling: assert property (@(posedge clock) disable iff (!reset) $onehot0(calling_vec));

endmodule

// File: tb/tb_teller_scheduler.sv
// Randomized and directed bench for teller_scheduler against a cycle-level behavioural model.
module tb_teller_scheduler;

   localparam int N     = 3;
   localparam int TOUT  = 15;
   localparam int GUARD = 4;
   localparam int S_OFF = 0, S_FREE = 1, S_CALL = 2, S_SERV = 3;
   localparam int M_IDLE = 0, M_CALL = 1, M_GUARD = 2;

   logic reset = 1'b0;
   logic clock = 1'b0;
   always #5 clock = ~clock;

   teller_scheduler_if #(.n(N)) bus ();

   teller_scheduler #(.n(N), .CALL_TIMEOUT(TOUT), .GUARD(GUARD)) dut (
      .reset (reset),
      .clock (clock),
      .bus   (bus.slave)
   );

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Behavioural model state
   int m_st [3];
   int m_disp, m_g, m_last, m_age, m_guard_left, m_noshow, m_tc;
   bit m_leave;

   task automatic model_reset();
      for (int i = 0; i < 3; i++) m_st[i] = S_OFF;
      m_disp = M_IDLE; m_g = 0; m_last = 2; m_age = 0; m_guard_left = 0;
      m_noshow = 0; m_tc = 0; m_leave = 0;
   endtask

   task automatic model_clock();
      int  nst [3];
      int  pick;
      bit  tmo;
      logic [2:0] on, ack, done;
      on = bus.tellerOn; ack = bus.custAck; done = bus.tellerDone;
      pick = -1; tmo = 0; m_leave = 0;
      case (m_disp)
         M_IDLE: if (!bus.emptyFlag && bus.Pcount != 0) begin
            for (int k = 1; k <= 3; k++) begin
               int c;
               c = (m_last + k) % 3;
               if (pick < 0 && m_st[c] == S_FREE && on[c]) pick = c;
            end
            if (pick >= 0) begin
               m_g = pick; m_last = pick; m_age = 0; m_disp = M_CALL;
            end
         end
         M_CALL: begin
            if (!on[m_g]) m_disp = M_IDLE;
            else if (ack[m_g]) begin
               m_leave = 1; m_disp = M_GUARD; m_guard_left = GUARD;
            end else if (m_age == TOUT - 1) begin
               m_leave = 1; m_disp = M_GUARD; m_guard_left = GUARD; tmo = 1;
               if (m_noshow < 255) m_noshow++;
            end else m_age++;
         end
         default: begin
            m_guard_left--;
            if (m_guard_left == 0) m_disp = M_IDLE;
         end
      endcase
      for (int i = 0; i < 3; i++) begin
         nst[i] = m_st[i];
         if (!on[i]) nst[i] = S_OFF;
         else if (m_st[i] == S_OFF) nst[i] = S_FREE;
         else if (m_st[i] == S_FREE && pick == i) nst[i] = S_CALL;
         else if (m_st[i] == S_CALL && ack[i]) nst[i] = S_SERV;
         else if (m_st[i] == S_CALL && tmo && m_g == i) nst[i] = S_FREE;
         else if (m_st[i] == S_SERV && done[i]) nst[i] = S_FREE;
      end
      for (int i = 0; i < 3; i++) m_st[i] = nst[i];
      m_tc = int'(on[0]) + int'(on[1]) + int'(on[2]);
   endtask

   task automatic step();
      @(posedge clock);
      if (!reset) model_reset();
      else        model_clock();
      @(negedge clock);
      cyc++;
      bus.custAck    = 3'b000;
      bus.tellerDone = 3'b000;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b0;
      bus.tellerOn = 3'b000; bus.tellerDone = 3'b000; bus.custAck = 3'b000;
      bus.Pcount = '0; bus.emptyFlag = 1'b1;
      model_reset();
      repeat (2) step();
      reset = 1'b1;
   endtask

   task automatic wait_call(input int lim, output bit ok);
      for (int k = 0; k < lim && !bus.callValid; k++) step();
      ok = bus.callValid;
   endtask

   task automatic test_reset();
      do_reset();
      n_vec++;
      if ({bus.callValid, bus.callTeller, bus.leaveN, bus.busy, bus.Tcount, bus.noShowCount} !==
          {1'b0, 2'd0, 1'b1, 3'b000, 2'd0, 8'd0}) begin
         n_err++;
         $display("FAIL reset_values: cv=%b ct=%0d ln=%b busy=%b tc=%0d ns=%0d, need 0 0 1 000 0 0",
                  bus.callValid, bus.callTeller, bus.leaveN, bus.busy, bus.Tcount, bus.noShowCount);
      end
   endtask

   task automatic test_single();
      bit ok;
      do_reset();
      bus.tellerOn = 3'b001; bus.Pcount = 4'd2; bus.emptyFlag = 1'b0;
      step();
      n_vec++;
      if (bus.Tcount !== 2'd1) begin n_err++; $display("FAIL single_tcount: got %0d need 1", bus.Tcount); end
      wait_call(10, ok);
      n_vec++;
      if (!ok || bus.callTeller !== 2'd1) begin
         n_err++; $display("FAIL single_call: cv=%b ct=%0d need 1 1", bus.callValid, bus.callTeller);
      end
      bus.custAck = 3'b001;
      step();
      n_vec++;
      if ({bus.leaveN, bus.busy, bus.callValid, bus.callTeller} !== {1'b0, 3'b001, 1'b0, 2'd0}) begin
         n_err++;
         $display("FAIL single_ack: ln=%b busy=%b cv=%b ct=%0d need 0 001 0 0",
                  bus.leaveN, bus.busy, bus.callValid, bus.callTeller);
      end
      step();
      n_vec++;
      if (bus.leaveN !== 1'b1) begin n_err++; $display("FAIL single_leave_width: ln=%b need 1", bus.leaveN); end
   endtask

   task automatic test_round_robin();
      int exp_seq [4] = '{1, 2, 3, 1};
      int last_leave, t;
      bit ok;
      do_reset();
      bus.tellerOn = 3'b111; bus.Pcount = 4'd5; bus.emptyFlag = 1'b0;
      last_leave = -100;
      for (int j = 0; j < 4; j++) begin
         wait_call(20, ok);
         n_vec++;
         if (!ok || bus.callTeller !== 2'(exp_seq[j])) begin
            n_err++; $display("FAIL rr_order[%0d]: cv=%b ct=%0d need %0d", j, bus.callValid, bus.callTeller, exp_seq[j]);
         end
         if (j > 0) begin
            n_vec++;
            if (cyc - last_leave < GUARD + 1) begin
               n_err++; $display("FAIL rr_spacing[%0d]: gap %0d need >= %0d", j, cyc - last_leave, GUARD + 1);
            end
         end
         t = (bus.callTeller == 0) ? 1 : int'(bus.callTeller);
         bus.custAck = 3'(1 << (t - 1));
         step();
         last_leave = cyc;
         n_vec++;
         if (bus.leaveN !== 1'b0) begin n_err++; $display("FAIL rr_leave[%0d]: ln=%b need 0", j, bus.leaveN); end
         bus.tellerDone = 3'(1 << (t - 1));
         step();
      end
   endtask

   task automatic test_timeout();
      int hi;
      bit ok;
      do_reset();
      bus.tellerOn = 3'b001; bus.Pcount = 4'd3; bus.emptyFlag = 1'b0;
      wait_call(10, ok);
      hi = 0;
      for (int k = 0; k < 40 && bus.callValid; k++) begin hi++; step(); end
      n_vec++;
      if (hi != TOUT) begin n_err++; $display("FAIL to_call_width: got %0d need %0d", hi, TOUT); end
      n_vec++;
      if (bus.leaveN !== 1'b0) begin n_err++; $display("FAIL to_leave: ln=%b need 0", bus.leaveN); end
      n_vec++;
      if (bus.noShowCount !== 8'd1 || bus.busy !== 3'b000) begin
         n_err++; $display("FAIL to_noshow: ns=%0d busy=%b need 1 000", bus.noShowCount, bus.busy);
      end
      wait_call(GUARD + 3, ok);
      n_vec++;
      if (!ok || bus.callTeller !== 2'd1) begin
         n_err++; $display("FAIL to_refree: cv=%b ct=%0d need 1 1", bus.callValid, bus.callTeller);
      end
   endtask

   task automatic test_abort();
      bit ok, bad;
      do_reset();
      bus.tellerOn = 3'b011; bus.Pcount = 4'd3; bus.emptyFlag = 1'b0;
      wait_call(10, ok);
      bus.custAck = 3'b001;
      step();
      wait_call(20, ok);
      n_vec++;
      if (!ok || bus.callTeller !== 2'd2 || bus.Tcount !== 2'd2) begin
         n_err++; $display("FAIL abort_setup: cv=%b ct=%0d tc=%0d need 1 2 2", bus.callValid, bus.callTeller, bus.Tcount);
      end
      bus.tellerOn = 3'b001;
      step();
      n_vec++;
      if ({bus.callValid, bus.callTeller, bus.leaveN, bus.Tcount} !== {1'b0, 2'd0, 1'b1, 2'd1}) begin
         n_err++;
         $display("FAIL abort_drop: cv=%b ct=%0d ln=%b tc=%0d need 0 0 1 1",
                  bus.callValid, bus.callTeller, bus.leaveN, bus.Tcount);
      end
      bad = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (bus.leaveN !== 1'b1 || bus.callValid !== 1'b0 || bus.busy !== 3'b001) bad = 1;
      end
      n_vec++;
      if (bad) begin
         n_err++; $display("FAIL abort_quiet: ln=%b cv=%b busy=%b need 1 0 001", bus.leaveN, bus.callValid, bus.busy);
      end
   endtask

   task automatic test_ack_race();
      bit ok;
      do_reset();
      bus.tellerOn = 3'b001; bus.Pcount = 4'd3; bus.emptyFlag = 1'b0;
      wait_call(10, ok);
      repeat (TOUT - 1) step();
      n_vec++;
      if (bus.callValid !== 1'b1) begin n_err++; $display("FAIL race_still_calling: cv=%b need 1", bus.callValid); end
      bus.custAck = 3'b001;
      step();
      n_vec++;
      if ({bus.leaveN, bus.busy, bus.noShowCount} !== {1'b0, 3'b001, 8'd0}) begin
         n_err++; $display("FAIL race_ack_wins: ln=%b busy=%b ns=%0d need 0 001 0", bus.leaveN, bus.busy, bus.noShowCount);
      end
      do_reset();
      bus.tellerOn = 3'b011; bus.Pcount = 4'd3; bus.emptyFlag = 1'b0;
      wait_call(10, ok);
      bus.custAck = 3'b010;
      step();
      n_vec++;
      if ({bus.callValid, bus.callTeller, bus.leaveN, bus.busy} !== {1'b1, 2'd1, 1'b1, 3'b000}) begin
         n_err++;
         $display("FAIL stray_ack: cv=%b ct=%0d ln=%b busy=%b need 1 1 1 000",
                  bus.callValid, bus.callTeller, bus.leaveN, bus.busy);
      end
   endtask

   task automatic test_reset_mid_call();
      bit ok, bad;
      do_reset();
      bus.tellerOn = 3'b001; bus.Pcount = 4'd3; bus.emptyFlag = 1'b0;
      wait_call(10, ok);
      repeat (3) step();
      #2 reset = 1'b0;
      #1;
      model_reset();
      n_vec++;
      if ({bus.callValid, bus.callTeller, bus.leaveN, bus.busy, bus.Tcount, bus.noShowCount} !==
          {1'b0, 2'd0, 1'b1, 3'b000, 2'd0, 8'd0}) begin
         n_err++;
         $display("FAIL midcall_reset: cv=%b ct=%0d ln=%b busy=%b tc=%0d ns=%0d need 0 0 1 000 0 0",
                  bus.callValid, bus.callTeller, bus.leaveN, bus.busy, bus.Tcount, bus.noShowCount);
      end
      bad = 0;
      repeat (3) begin
         @(negedge clock);
         if (bus.leaveN !== 1'b1) bad = 1;
      end
      reset = 1'b1;
      step();
      if (bus.leaveN !== 1'b1) bad = 1;
      n_vec++;
      if (bad) begin n_err++; $display("FAIL midcall_no_leave: ln=%b need 1", bus.leaveN); end
   endtask

   task automatic test_random();
      logic [3:0] pc;
      do_reset();
      bus.tellerOn = 3'b111;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 31) == 0) bus.tellerOn[$urandom_range(0, 2)] = ~bus.tellerOn[$urandom_range(0, 2)];
         if ($urandom_range(0, 63) == 0) bus.tellerOn = 3'b111;
         for (int i = 0; i < 3; i++) begin
            bus.custAck[i]    = ($urandom_range(0, 5) == 0);
            bus.tellerDone[i] = ($urandom_range(0, 7) == 0);
         end
         pc = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
         bus.Pcount    = pc;
         bus.emptyFlag = ($urandom_range(0, 9) == 0) ? 1'($urandom_range(0, 1)) : (pc == 0);
         step();
         n_vec++;
         if (bus.callValid !== (m_disp == M_CALL)) begin
            n_err++; $display("FAIL rnd_callValid @%0d: got %b need %b", cyc, bus.callValid, m_disp == M_CALL);
         end
         n_vec++;
         if (bus.callTeller !== 2'((m_disp == M_CALL) ? m_g + 1 : 0)) begin
            n_err++; $display("FAIL rnd_callTeller @%0d: got %0d need %0d", cyc, bus.callTeller, (m_disp == M_CALL) ? m_g + 1 : 0);
         end
         n_vec++;
         if (bus.leaveN !== !m_leave) begin
            n_err++; $display("FAIL rnd_leaveN @%0d: got %b need %b", cyc, bus.leaveN, !m_leave);
         end
         n_vec++;
         if (bus.busy !== {m_st[2] == S_SERV, m_st[1] == S_SERV, m_st[0] == S_SERV}) begin
            n_err++; $display("FAIL rnd_busy @%0d: got %b need %b%b%b", cyc, bus.busy,
                              m_st[2] == S_SERV, m_st[1] == S_SERV, m_st[0] == S_SERV);
         end
         n_vec++;
         if (bus.Tcount !== 2'(m_tc)) begin
            n_err++; $display("FAIL rnd_Tcount @%0d: got %0d need %0d", cyc, bus.Tcount, m_tc);
         end
         n_vec++;
         if (bus.noShowCount !== 8'(m_noshow)) begin
            n_err++; $display("FAIL rnd_noShowCount @%0d: got %0d need %0d", cyc, bus.noShowCount, m_noshow);
         end
      end
   endtask

   initial begin
      bus.tellerOn = 3'b000; bus.tellerDone = 3'b000; bus.custAck = 3'b000;
      bus.Pcount = '0; bus.emptyFlag = 1'b1;
      model_reset();
      test_reset();
      test_single();
      test_round_robin();
      test_timeout();
      test_abort();
      test_ack_race();
      test_reset_mid_call();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation still running at time %0t, need completion", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
